// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a toggle-triggered ALU: issues one
// operation at a time and returns its result, or a timeout error, to the owner.
module alu_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic         req1,
  input  logic [131:0] op0,
  input  logic [131:0] op1,
  output logic         grant0,
  output logic         grant1,
  output logic [131:0] alu_op,
  output logic         alu_trigger,
  input  logic         alu_ready,
  input  logic [96:0]  alu_res,
  output logic [96:0]  resp,
  output logic         resp_valid0,
  output logic         resp_valid1,
  output logic         resp_err,
  output logic         busy
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} arbState;

  arbState        state, nextState;
  logic [CW-1:0]  counter, nextCounter;
  logic           lastGrant, nextLastGrant;   // index of the most recent grant, also the response owner
  logic [1:0]     readySync;
  logic           readyPrev;
  logic           readyRise;
  logic           pickOne;
  logic           nextGrant0, nextGrant1;
  logic [131:0]   nextAluOp;
  logic           nextTrigger;
  logic [96:0]    nextResp;
  logic           nextValid0, nextValid1, nextErr;

  // NOTE: alu_ready comes from another clock domain; only readySync[1] may feed logic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      readySync <= 2'b00;
      readyPrev <= 1'b0;
    end else begin
      readySync <= {readySync[0], alu_ready};
      readyPrev <= readySync[1];
    end
  end

  assign readyRise = readySync[1] & ~readyPrev;
  assign busy      = (state != IDLE);

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    nextState     = state;
    nextCounter   = counter;
    nextLastGrant = lastGrant;
    nextGrant0    = 1'b0;
    nextGrant1    = 1'b0;
    nextAluOp     = alu_op;
    nextTrigger   = alu_trigger;
    nextResp      = resp;
    nextValid0    = 1'b0;
    nextValid1    = 1'b0;
    nextErr       = 1'b0;
    pickOne       = req1 && (!req0 || !lastGrant);

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          nextLastGrant = pickOne;
          nextGrant0    = !pickOne;
          nextGrant1    = pickOne;
          nextAluOp     = pickOne ? op1 : op0;
          nextTrigger   = !alu_trigger;
          nextCounter   = '0;
          nextState     = WAIT;
        end
      end
      WAIT: begin
        // A completion seen on the last allowed cycle still beats the timeout.
        if (readyRise) begin
          nextResp   = alu_res;
          nextValid0 = !lastGrant;
          nextValid1 = lastGrant;
          nextState  = RESP;
        end else if (counter == LAST_COUNT) begin
          nextResp   = '0;
          nextErr    = 1'b1;
          nextValid0 = !lastGrant;
          nextValid1 = lastGrant;
          nextState  = RESP;
        end else begin
          nextCounter = counter + 1'b1;
        end
      end
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      counter     <= '0;
      lastGrant   <= 1'b1;
      grant0      <= 1'b0;
      grant1      <= 1'b0;
      alu_op      <= '0;
      alu_trigger <= 1'b0;
      resp        <= '0;
      resp_valid0 <= 1'b0;
      resp_valid1 <= 1'b0;
      resp_err    <= 1'b0;
    end else begin
      state       <= nextState;
      counter     <= nextCounter;
      lastGrant   <= nextLastGrant;
      grant0      <= nextGrant0;
      grant1      <= nextGrant1;
      alu_op      <= nextAluOp;
      alu_trigger <= nextTrigger;
      resp        <= nextResp;
      resp_valid0 <= nextValid0;
      resp_valid1 <= nextValid1;
      resp_err    <= nextErr;
    end
  end

endmodule
